imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-stream loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes big-endian 32-bit words into instruction memory while holding the CPU.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    FIN,
    FAIL
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t        state_reg, state_next;
  logic [15:0]   len_reg, len_next;
  logic [15:0]   idx_reg, idx_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [23:0]   shift_reg, shift_next;
  logic [7:0]    csum_reg, csum_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;

  logic          xfer;
  logic [15:0]   len_full;
  logic          len_bad;

  assign byte_ready = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                      (state_reg == DATA)   || (state_reg == CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign len_full   = {len_reg[15:8], byte_in};
  assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_W);

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    csum_next  = csum_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;

    case (state_reg)
      IDLE, FIN, FAIL: begin
        if (start) begin
          state_next = LEN_HI;
          len_next   = 16'd0;
          idx_next   = 16'd0;
          cnt_next   = 2'd0;
          csum_next  = 8'd0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_next[15:8] = byte_in;
          state_next     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_next   = len_full;
          state_next = len_bad ? FAIL : DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          csum_next  = csum_reg ^ byte_in;
          cnt_next   = cnt_reg + 2'd1;
          shift_next = {shift_reg[15:0], byte_in};
          // Fourth byte completes a word: the write strobe lands on the next cycle.
          if (cnt_reg == 2'd3) begin
            we_next    = 1'b1;
            addr_next  = idx_reg[AW-1:0];
            wdata_next = {shift_reg, byte_in};
            idx_next   = idx_reg + 16'd1;
            if (idx_reg == len_reg - 16'd1) begin
              state_next = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          state_next = (byte_in == csum_reg) ? FIN : FAIL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= 16'd0;
      idx_reg   <= 16'd0;
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
      csum_reg  <= 8'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      csum_reg  <= csum_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = byte_ready;
  assign cpu_hold  = byte_ready;
  assign done      = (state_reg == FIN);
  assign err       = (state_reg == FAIL);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle-by-cycle vector table for short streams, then
// full-depth, flow-controlled and reset-abort load sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, busy, cpu_hold, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  imem_loader #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t wr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{mem_addr, mem_wdata, cyc});
  end

  typedef struct {
    logic        rst, start, valid;
    logic [7:0]  b;
    logic        ready, we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        busy, done, err;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] b, logic rdy,
                              logic we, logic [9:0] a, logic [31:0] wd,
                              logic bz, logic dn, logic er);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.b = b;
    t.ready = rdy; t.we = we; t.addr = a; t.wd = wd;
    t.busy = bz; t.done = dn; t.err = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(int i);
    logic [31:0] r;
    r[31:24] = 8'(i) ^ 8'hA5;
    r[23:16] = 8'(i >> 8);
    r[15:8]  = 8'(i * 7) ^ 8'h3C;
    r[7:0]   = 8'(i * 13);
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard = 0;
    bit sent = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!sent) begin
      sent = byte_ready;
      @(negedge clk);
      guard++;
      if (!sent && guard > 20) begin
        chk("send_ready_timeout", 64'(byte_ready), 64'd1);
        return;
      end
    end
  endtask

  task automatic load(input int n, input int gap_pct, input bit spacing, input string tag);
    logic [7:0]  cs = 8'd0;
    logic [31:0] w;
    int bad = 0;
    int bad_gap = 0;
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'(n >> 8), gap_pct);
    send_byte(8'(n), gap_pct);
    for (int i = 0; i < n; i++) begin
      w = word_of(i);
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[k*8 +: 8], gap_pct);
        cs ^= w[k*8 +: 8];
      end
    end
    send_byte(cs, gap_pct);
    byte_valid = 1'b0;
    chk({tag, "_writes"}, 64'(wr_q.size()), 64'(n));
    for (int i = 0; i < wr_q.size() && i < n; i++) begin
      if (wr_q[i].addr !== 10'(i) || wr_q[i].data !== word_of(i)) begin
        if (bad == 0)
          $display("FAIL %s_word%0d: got addr %0d data %h expected addr %0d data %h",
                   tag, i, wr_q[i].addr, wr_q[i].data, i, word_of(i));
        bad++;
      end
      if (i > 0 && wr_q[i].cyc - wr_q[i-1].cyc != 4) bad_gap++;
    end
    chk({tag, "_bad_words"}, 64'(bad), 64'd0);
    if (spacing) chk({tag, "_bad_spacing"}, 64'(bad_gap), 64'd0);
    chk({tag, "_flags"}, {61'd0, done, err, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
  endtask

  vec_t tv[$];
  localparam logic [31:0] W0 = 32'h44200053;

  initial begin
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    repeat (2) @(negedge clk);

    //           rst start vld byte | rdy we addr wd   busy done err
    tv.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 1, 8'hAA, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 0, 0, 8'h11, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h01, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h44, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 1, 1, 8'h20, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 0, 8'hFF, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h53, 1, 0, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h37, 1, 1, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, W0, 0, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, W0, 0, 1, 0));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h01, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h44, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h20, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h53, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h36, 1, 1, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, W0, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, W0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, W0, 0, 0, 1));
    tv.push_back(mk(0, 0, 1, 8'h04, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 8'h01, 1, 0, 0, W0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, W0, 0, 0, 1));
    tv.push_back(mk(1, 1, 1, 8'h00, 0, 0, 0, W0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0));

    foreach (tv[i]) begin
      rst = tv[i].rst; start = tv[i].start; byte_valid = tv[i].valid; byte_in = tv[i].b;
      #1;
      chk($sformatf("vec%0d", i),
          {18'd0, byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err},
          {18'd0, tv[i].ready, tv[i].we, tv[i].addr, tv[i].wd,
           tv[i].busy, tv[i].busy, tv[i].done, tv[i].err});
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;

    load(1024, 0, 1'b1, "full");
    load(1024, 50, 1'b0, "flow");

    // Abort: six words written, then reset lands together with word 6's last byte.
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    for (int i = 0; i < 7; i++) begin
      w = word_of(i);
      for (int k = 3; k >= 0; k--) begin
        if (i == 6 && k == 0) break;
        send_byte(w[k*8 +: 8], 0);
      end
    end
    w = word_of(6);
    byte_in = w[7:0]; byte_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_writes", 64'(wr_q.size()), 64'd6);
    chk("abort_outputs",
        {20'd0, byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("abort_no_more_writes", 64'(wr_q.size()), 64'd6);
    chk("abort_idle", {62'd0, busy, mem_we}, 64'd0);

    load(3, 0, 1'b1, "reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
